// File: rtl/update_buf_pkg.sv
// Shared types and helpers for the update commit buffer.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package update_buf_pkg;

    // Commit sequencing: accept updates, let stragglers land, stream out, wait for the tail beat
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_FLUSH = 2'd3
    } ucb_state_t;

    localparam int LANE_WIDTH    = 16;
    localparam int MAX_BUS_WIDTH = 256;

    // Extract lane k from a packed lane bus (lane 0 sits in the LSBs)
    function automatic logic [LANE_WIDTH-1:0] lane_of(input logic [MAX_BUS_WIDTH-1:0] bus,
                                                      input int unsigned k);
        logic [MAX_BUS_WIDTH-1:0] shifted;
        shifted = bus >> (k * LANE_WIDTH);
        return shifted[LANE_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid the cycle after rd_en; contents are never cleared.
// Backpressure: none; rd_data holds its value while rd_en is low.
module sdp_ram #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds the last word when not reading
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/update_commit_buffer.sv
// Stages out-of-order multi-lane particle updates, then streams 0..high-water-mark on commit.
// Latency: first out_valid DRAIN_CYCLES+2 cycles after commit_in; 1 beat/cycle with out_ready high.
// Backpressure: out_ready stalls reads via a 2-entry skid FIFO; writes outside IDLE/DRAIN are dropped and flagged.
module update_commit_buffer
    import update_buf_pkg::*;
#(
    parameter int ADDR_WIDTH   = 7,
    parameter int RAM_WIDTH    = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_n,
    input  logic [ADDR_WIDTH-1:0]             wr_addr_in,
    input  logic [NUM_CHANNELS*RAM_WIDTH-1:0] wr_data_in,
    input  logic                              wr_valid_in,
    input  logic                              commit_in,
    output logic [ADDR_WIDTH-1:0]             out_addr,
    output logic [NUM_CHANNELS*RAM_WIDTH-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              idle,
    output logic                              commit_done,
    output logic [ADDR_WIDTH:0]               count,
    output logic                              wr_drop_err
);

    localparam int DW  = NUM_CHANNELS * RAM_WIDTH;
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ucb_state_t state, state_nxt;

    logic [DCW-1:0]        drain_cnt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  drain_last;
    logic                  rd_last;
    logic                  rd_issue;
    logic                  done_now;
    logic                  wr_accept;
    logic [ADDR_WIDTH:0]   wr_end;
    logic [ADDR_WIDTH:0]   count_grow;

    // Read pipeline stage (the RAM output register) and the skid FIFO behind it
    logic                  ram_vld;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DW-1:0]         ram_q;
    logic [ADDR_WIDTH-1:0] fifo_addr [0:1];
    logic [DW-1:0]         fifo_data [0:1];
    logic                  fifo_wp;
    logic                  fifo_rp;
    logic [1:0]            occ;
    logic [1:0]            outstanding;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  head_in_fifo;

    assign wr_accept  = wr_valid_in && (state == ST_IDLE || state == ST_DRAIN);
    assign wr_end     = {1'b0, wr_addr_in} + CNT_ONE;
    assign count_grow = (wr_accept && (wr_end > count)) ? wr_end : count;
    assign drain_last = (drain_cnt == DCW'(DRAIN_CYCLES - 1));
    assign rd_last    = ({1'b0, rd_ptr} == (count - CNT_ONE));

    // Reads in flight count against FIFO space so a stalled sink never overflows the skid
    assign outstanding  = occ + {1'b0, ram_vld};
    assign head_in_fifo = (occ != 2'd0);
    assign accept       = out_valid && out_ready;
    // The RAM word bypasses the FIFO only when the FIFO is empty and the sink takes it now
    assign push         = ram_vld && !(!head_in_fifo && out_ready);
    assign pop          = accept && head_in_fifo;

    // State register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (commit_in) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) state_nxt = (count_grow == '0) ? ST_IDLE : ST_READ;
            end
            ST_READ: begin
                if (rd_issue && rd_last) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (accept && outstanding == 2'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state outputs: read issue, completion, and the presented beat
    always_comb begin
        rd_issue  = (state == ST_READ) && (outstanding < 2'd2);
        done_now  = ((state == ST_DRAIN) && drain_last && (count_grow == '0)) ||
                    ((state == ST_FLUSH) && accept && (outstanding == 2'd1));
        idle      = (state == ST_IDLE);
        out_valid = head_in_fifo || ram_vld;
        out_addr  = '0;
        out_data  = '0;
        if (head_in_fifo) begin
            out_addr = fifo_addr[fifo_rp];
            out_data = fifo_data[fifo_rp];
        end else if (ram_vld) begin
            out_addr = ram_addr;
            out_data = ram_q;
        end
    end

    // Commit bookkeeping: drain timer, read pointer, high-water mark, error flag, done pulse
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt   <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_drop_err <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            commit_done <= done_now;
            count       <= done_now ? '0 : count_grow;
            if (wr_valid_in && !wr_accept) begin
                wr_drop_err <= 1'b1;
            end
            if (state == ST_IDLE && commit_in) begin
                drain_cnt <= '0;
                rd_ptr    <= '0;
            end else if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + DCW'(1);
            end
            // Hold at count-1 on the final read so the pointer never wraps
            if (rd_issue && !rd_last) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Read-in-flight tracking alongside the RAM output register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ram_vld  <= 1'b0;
            ram_addr <= '0;
        end else begin
            ram_vld <= rd_issue;
            if (rd_issue) begin
                ram_addr <= rd_ptr;
            end
        end
    end

    // Skid FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wp <= 1'b0;
            fifo_rp <= 1'b0;
            occ     <= 2'd0;
        end else begin
            if (push) fifo_wp <= ~fifo_wp;
            if (pop)  fifo_rp <= ~fifo_rp;
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    // Skid FIFO storage; contents are only meaningful under occ
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_addr[fifo_wp] <= ram_addr;
            fifo_data[fifo_wp] <= ram_q;
        end
    end

    sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DW)
    ) u_ram (
        .clk     (clk_in),
        .wr_en   (wr_accept),
        .wr_addr (wr_addr_in),
        .wr_data (wr_data_in),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_update_commit_buffer.sv
// Directed bench for update_commit_buffer: write tables, commit streams, stalls, drops, reset.
// Latency: checks first beat at DRAIN_CYCLES+2 and done timing against hand-derived cycles.
// Backpressure: drives out_ready patterns and checks beats hold while stalled.
`timescale 1ns/1ps
module tb_update_commit_buffer;
    import update_buf_pkg::*;

    localparam int AW    = 7;
    localparam int RW    = 16;
    localparam int NC    = 2;
    localparam int DC    = 2;
    localparam int DW    = NC * RW;
    localparam int DEPTH = 1 << AW;

    logic          clk_in      = 1'b0;
    logic          rst_n       = 1'b0;
    logic [AW-1:0] wr_addr_in  = '0;
    logic [DW-1:0] wr_data_in  = '0;
    logic          wr_valid_in = 1'b0;
    logic          commit_in   = 1'b0;
    logic          out_ready   = 1'b1;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          idle;
    logic          commit_done;
    logic [AW:0]   count;
    logic          wr_drop_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model   [0:DEPTH-1];
    bit            written [0:DEPTH-1];
    logic [DW-1:0] last_beat;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW:0]   exp_count;
    } wr_vec_t;

    always #5 clk_in = ~clk_in;

    update_commit_buffer #(
        .ADDR_WIDTH   (AW),
        .RAM_WIDTH    (RW),
        .NUM_CHANNELS (NC),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .wr_valid_in (wr_valid_in),
        .commit_in   (commit_in),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .idle        (idle),
        .commit_done (commit_done),
        .count       (count),
        .wr_drop_err (wr_drop_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int idx, input logic [RW-1:0] salt);
        logic [RW-1:0] l0;
        l0 = RW'(idx) * 16'h11 + salt;
        return {~l0, l0};
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid_in = 1'b1;
        wr_addr_in  = a;
        wr_data_in  = d;
        model[a]    = d;
        written[a]  = 1'b1;
        step;
        wr_valid_in = 1'b0;
    endtask

    task automatic write_range(input int n, input logic [RW-1:0] salt);
        for (int i = 0; i < n; i++) begin
            do_write(AW'(i), pat(i, salt));
        end
    endtask

    // Pulse commit and follow the stream; t counts cycles from the commit cycle (t=0)
    task automatic run_commit(input int exp_beats, input bit bp, input int wr_t,
                              input logic [AW-1:0] wr_a, input logic [DW-1:0] wr_d,
                              input bit wr_ok, input string tag);
        int            t;
        int            beats;
        int            first_vld;
        int            last_acc;
        bit            done;
        bit            prev_stall;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_data;
        commit_in = 1'b1;
        out_ready = 1'b1;
        step;
        commit_in  = 1'b0;
        t          = 1;
        beats      = 0;
        first_vld  = -1;
        last_acc   = -1;
        done       = 1'b0;
        prev_stall = 1'b0;
        p_addr     = '0;
        p_data     = '0;
        while (!done && t < 400) begin
            out_ready = bp ? ((t % 3) == 1) : 1'b1;
            if (t == wr_t) begin
                wr_valid_in = 1'b1;
                wr_addr_in  = wr_a;
                wr_data_in  = wr_d;
                if (wr_ok) begin
                    model[wr_a]   = wr_d;
                    written[wr_a] = 1'b1;
                end
            end else begin
                wr_valid_in = 1'b0;
            end
            if (t == 1) check({tag, " idle low after commit"}, idle, 0);
            if (prev_stall) begin
                check({tag, " hold valid"}, out_valid, 1);
                check({tag, " hold addr"}, out_addr, p_addr);
                check({tag, " hold data"}, out_data, p_data);
            end
            if (out_valid && first_vld < 0) begin
                first_vld = t;
                check({tag, " first valid cycle"}, t, DC + 2);
            end
            if (out_valid && out_ready) begin
                check({tag, " beat addr"}, out_addr, beats);
                if (beats < DEPTH && written[beats]) begin
                    check({tag, " beat data"}, out_data, model[beats]);
                end
                last_beat = out_data;
                beats++;
                last_acc = t;
            end
            prev_stall = out_valid && !out_ready;
            p_addr     = out_addr;
            p_data     = out_data;
            if (commit_done) begin
                done = 1'b1;
                check({tag, " commit_done cycle"}, t, (beats > 0) ? last_acc + 1 : DC + 1);
            end
            step;
            t++;
        end
        wr_valid_in = 1'b0;
        out_ready   = 1'b1;
        check({tag, " commit_done seen"}, done, 1);
        check({tag, " beat count"}, beats, exp_beats);
        check({tag, " commit_done one cycle"}, commit_done, 0);
        check({tag, " count cleared"}, count, 0);
        check({tag, " idle after"}, idle, 1);
        check({tag, " no trailing valid"}, out_valid, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wr_vec_t tbl [4];
        int      beats;

        // Basic-swap writes arrive out of order; count tracks the high-water mark
        tbl[0] = '{addr: 7'd2, data: pat(2, 16'h0), exp_count: 8'd3};
        tbl[1] = '{addr: 7'd0, data: pat(0, 16'h0), exp_count: 8'd3};
        tbl[2] = '{addr: 7'd3, data: pat(3, 16'h0), exp_count: 8'd4};
        tbl[3] = '{addr: 7'd1, data: pat(1, 16'h0), exp_count: 8'd4};

        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

        // Reset values
        #12;
        check("reset idle", idle, 1);
        check("reset out_valid", out_valid, 0);
        check("reset commit_done", commit_done, 0);
        check("reset count", count, 0);
        check("reset wr_drop_err", wr_drop_err, 0);
        check("reset out_addr", out_addr, 0);
        check("reset out_data", out_data, 0);
        step;
        rst_n = 1'b1;
        step;

        // Empty commit: no beats, done after DRAIN_CYCLES+1
        run_commit(0, 1'b0, -1, '0, '0, 1'b0, "empty");

        // Basic swap from the table
        for (int i = 0; i < 4; i++) begin
            do_write(tbl[i].addr, tbl[i].data);
            check("table count", count, tbl[i].exp_count);
        end
        run_commit(4, 1'b0, -1, '0, '0, 1'b0, "basic");
        check("basic last lane0", lane_of(MAX_BUS_WIDTH'(last_beat), 0), 16'h0033);
        check("basic last lane1", lane_of(MAX_BUS_WIDTH'(last_beat), 1), 16'hffcc);
        check("basic no drop", wr_drop_err, 0);

        // Backpressure: out_ready 1,0,0,1,... over 8 beats
        write_range(8, 16'h0500);
        check("bp count before commit", count, 8);
        run_commit(8, 1'b1, -1, '0, '0, 1'b0, "bp");

        // Late write in DRAIN raises the high-water mark
        write_range(5, 16'h0a00);
        run_commit(6, 1'b0, 1, 7'd5, 32'hbeef_cafe, 1'b1, "late");
        check("late no drop", wr_drop_err, 0);

        // Write during READ is dropped; index 2 keeps its old value
        write_range(8, 16'h0c00);
        run_commit(8, 1'b0, 3, 7'd2, 32'hdead_0002, 1'b0, "drop");
        check("drop err set", wr_drop_err, 1);
        step;
        check("drop err sticky", wr_drop_err, 1);

        // Reset asserted mid-stream after beat 1
        write_range(8, 16'h0e00);
        commit_in = 1'b1;
        step;
        commit_in = 1'b0;
        beats     = 0;
        for (int t = 1; t < 50 && beats < 2; t++) begin
            if (out_valid && out_ready) beats++;
            if (beats < 2) step;
        end
        check("rst beats before reset", beats, 2);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst out_valid async", out_valid, 0);
        check("rst idle", idle, 1);
        check("rst count", count, 0);
        check("rst commit_done", commit_done, 0);
        check("rst drop err cleared", wr_drop_err, 0);
        step;
        step;
        rst_n = 1'b1;
        step;
        run_commit(0, 1'b0, -1, '0, '0, 1'b0, "post-reset empty");

        // Full index range: top index gives count=DEPTH, stream stops without wrapping
        do_write(7'd127, 32'h1234_5678);
        check("full count", count, DEPTH);
        run_commit(DEPTH, 1'b0, -1, '0, '0, 1'b0, "full");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
